// File: rtl/dac_24bit_sd_pkg.sv
// Shared types and constants for the 24-bit first-order delta-sigma DAC.
package dac_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int CODE_W         = 24;
    localparam int MAX_POS_CODE   = 8388607;
    localparam int MIN_NEG_CODE   = -8388608;
    localparam int CHARGE_W       = 20;
    localparam int CHARGE_PER_BIT = 3;

    function automatic logic [4:0] popcount24(input logic [CODE_W-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < CODE_W; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dac_24bit_sd_mod1.sv
// First-order delta-sigma core: 24-bit accumulator whose carry-out is the registered bit.
module dac_sd_mod1
    import dac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [CODE_W-1:0] u_i,
    output logic              bit_o
);

    logic [CODE_W-1:0] acc_q, acc_d;
    logic              bit_q, bit_d;
    logic [CODE_W:0]   sum;

    // Clear wins over enable so the last RUN edge can park the core at zero.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, u_i};
        acc_d = acc_q;
        bit_d = bit_q;
        if (clr_i) begin
            acc_d = '0;
            bit_d = 1'b0;
        end else if (en_i) begin
            acc_d = sum[CODE_W-1:0];
            bit_d = sum[CODE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            bit_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            bit_q <= bit_d;
        end
    end

    assign bit_o = bit_q;

endmodule

// File: rtl/dac_24bit_sd.sv
// 24-bit delta-sigma DAC top: hold/active buffering, IDLE/RUN sequencing, modulator.
// Optional bit-change charge monitor is built only when DAC_CHARGE_MON_EN is defined.
module dac_24bit_sd
    import dac_pkg::*;
#(
    parameter int OSR          = 64,
    parameter int CNT_W        = 16,
    parameter int CHARGE_LIMIT = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [CODE_W-1:0]   sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                pdm_out,
    output logic                busy,
    output logic                underrun,
    output logic [CHARGE_W-1:0] charge,
    output logic                charge_ovr,
    input  logic                charge_clr
);

    // Handshake: a sample moves into the hold register on any edge where
    // sample_valid && sample_ready; sample_ready is simply "hold register empty".
    state_e            state_q, state_d;
    logic [CODE_W-1:0] hold_q, hold_d;
    logic [CODE_W-1:0] active_q, active_d;
    logic              hold_full_q, hold_full_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              underrun_q, underrun_d;
    logic              xfer, load, boundary;
    logic              mod_en, mod_clr;
    logic [CODE_W-1:0] u;

    assign xfer     = sample_valid && !hold_full_q;
    assign boundary = (cnt_q == CNT_W'(OSR - 1));
    assign u        = {~active_q[CODE_W-1], active_q[CODE_W-2:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        underrun_d = 1'b0;
        load       = 1'b0;
        mod_en     = 1'b0;
        mod_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                mod_clr = 1'b1;
                if (enable && hold_full_q) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                mod_en = 1'b1;
                if (boundary) begin
                    cnt_d = '0;
                    if (!enable) begin
                        state_d = IDLE;
                        mod_clr = 1'b1;
                    end else if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        active_d    = load ? hold_q : active_q;
        hold_d      = xfer ? sample_in : hold_q;
        hold_full_d = (hold_full_q && !load) || xfer;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            active_q    <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            active_q    <= active_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            underrun_q  <= underrun_d;
        end
    end

    dac_sd_mod1 u_mod (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (mod_en),
        .clr_i (mod_clr),
        .u_i   (u),
        .bit_o (pdm_out)
    );

    assign sample_ready = !hold_full_q;
    assign busy         = (state_q == RUN);
    assign underrun     = underrun_q;

`ifdef DAC_CHARGE_MON_EN
    logic [CHARGE_W-1:0] charge_q, charge_d;
    logic                charge_ovr_q, charge_ovr_d;
    logic [CHARGE_W:0]   charge_sum;

    // Old active vs incoming hold gives the bits that flip on this load.
    always_comb begin
        charge_sum   = {1'b0, charge_q}
                     + (CHARGE_W + 1)'(CHARGE_PER_BIT * int'(popcount24(active_q ^ hold_q)));
        charge_d     = charge_q;
        charge_ovr_d = charge_ovr_q;
        if (charge_clr) begin
            charge_d     = '0;
            charge_ovr_d = 1'b0;
        end else begin
            if (load) begin
                charge_d = charge_sum[CHARGE_W] ? '1 : charge_sum[CHARGE_W-1:0];
            end
            charge_ovr_d = charge_ovr_q || (int'({12'd0, charge_d}) > CHARGE_LIMIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            charge_q     <= '0;
            charge_ovr_q <= 1'b0;
        end else begin
            charge_q     <= charge_d;
            charge_ovr_q <= charge_ovr_d;
        end
    end

    assign charge     = charge_q;
    assign charge_ovr = charge_ovr_q;
`else
    logic unused_charge;
    assign unused_charge = charge_clr ^ (CHARGE_LIMIT < 0);
    assign charge        = '0;
    assign charge_ovr    = 1'b0;
`endif

endmodule

// File: tb/tb_dac_24bit_sd.sv
// Self-checking bench for dac_24bit_sd: cycle reference model feeds an expected queue,
// modulator output derived from the running input sum (ones = floor(sum / 2^24)).
module tb_dac_24bit_sd;

    localparam int OSR   = 4;
    localparam int CNT_W = 3;
    localparam int LIMIT = 10;
    localparam int W     = 25;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [23:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        pdm_out;
    logic        busy;
    logic        underrun;
    logic [19:0] charge;
    logic        charge_ovr;
    logic        charge_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    // model state
    logic        m_run;
    int          m_phase;
    logic [23:0] m_cur;
    longint      m_sum;
    logic [23:0] m_hold[$];
    int          m_charge;
    logic        m_ovr;

    dac_24bit_sd #(
        .OSR          (OSR),
        .CNT_W        (CNT_W),
        .CHARGE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pdm_out      (pdm_out),
        .busy         (busy),
        .underrun     (underrun),
        .charge       (charge),
        .charge_ovr   (charge_ovr),
        .charge_clr   (charge_clr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [23:0] code);
        int n;
        n = 0;
        while (!sample_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!sample_ready) begin
            chk("send_ready_timeout", int'(sample_ready), 1);
        end else begin
            sample_valid = 1'b1;
            sample_in    = code;
            tick(1);
            sample_valid = 1'b0;
            sample_in    = 24'($urandom);
        end
    endtask

    // ---------------- reference model ----------------
    // Evaluated on pre-edge inputs; pushes what the outputs must be after this edge.
    always @(posedge clk) begin
        logic        e_pdm, e_busy, e_under, load;
        logic [23:0] old;
        longint      prev;
        if (!rst_n) begin
            m_run    = 1'b0;
            m_phase  = 0;
            m_cur    = '0;
            m_sum    = 0;
            m_hold.delete();
            m_charge = 0;
            m_ovr    = 1'b0;
            e_pdm    = 1'b0;
            e_under  = 1'b0;
        end else begin
            e_under = 1'b0;
            load    = 1'b0;
            old     = m_cur;
            if (!m_run) begin
                e_pdm = 1'b0;
                if (enable && m_hold.size() > 0) begin
                    m_cur   = m_hold.pop_front();
                    m_run   = 1'b1;
                    m_phase = 0;
                    m_sum   = 0;
                    load    = 1'b1;
                end
            end else begin
                prev  = m_sum;
                m_sum = m_sum + longint'(m_cur ^ 24'h800000);
                e_pdm = ((m_sum >> 24) != (prev >> 24));
                if (m_phase == OSR - 1) begin
                    m_phase = 0;
                    if (!enable) begin
                        m_run = 1'b0;
                        e_pdm = 1'b0;
                    end else if (m_hold.size() > 0) begin
                        m_cur = m_hold.pop_front();
                        load  = 1'b1;
                    end else begin
                        e_under = 1'b1;
                    end
                end else begin
                    m_phase++;
                end
            end
`ifdef DAC_CHARGE_MON_EN
            if (charge_clr) begin
                m_charge = 0;
                m_ovr    = 1'b0;
            end else begin
                if (load) begin
                    m_charge = m_charge + 3 * $countones(old ^ m_cur);
                    if (m_charge > (1 << 20) - 1) m_charge = (1 << 20) - 1;
                end
                if (m_charge > LIMIT) m_ovr = 1'b1;
            end
`endif
            if (sample_valid && sample_ready) m_hold.push_back(sample_in);
        end
        e_busy = m_run;
        exp_q.push_back({e_pdm, e_busy, e_under, (m_hold.size() == 0), 20'(m_charge), m_ovr});
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pdm_out",      int'(pdm_out),      int'(e[24]));
            chk("busy",         int'(busy),         int'(e[23]));
            chk("underrun",     int'(underrun),     int'(e[22]));
            chk("sample_ready", int'(sample_ready), int'(e[21]));
            chk("charge",       int'(charge),       int'(e[20:1]));
            chk("charge_ovr",   int'(charge_ovr),   int'(e[0]));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [23:0] code;
        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        charge_clr   = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // mid-scale sample alone, then underruns at later boundaries
        enable = 1'b1;
        send(24'h000000);
        tick(5 * OSR);

        // negative full scale stream, then positive full scale
        for (int i = 0; i < 8; i++) send(24'h800000);
        for (int i = 0; i < 4; i++) send(24'h7FFFFF);
        tick(2 * OSR);

        // +2.5 V stream
        for (int i = 0; i < 10; i++) send(24'h400000);

        // enable drops mid-period with a sample queued in hold
        send(24'h123456);
        send(24'h654321);
        tick(1);
        enable = 1'b0;
        tick(4 * OSR);
        enable = 1'b1;
        tick(3 * OSR);

        // asynchronous reset mid-run
        send(24'h2AAAAA);
        send(24'($urandom));
        tick(OSR + 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pdm",    int'(pdm_out),      0);
        chk("async_rst_busy",   int'(busy),         0);
        chk("async_rst_under",  int'(underrun),     0);
        chk("async_rst_ready",  int'(sample_ready), 1);
        chk("async_rst_charge", int'(charge),       0);
        chk("async_rst_ovr",    int'(charge_ovr),   0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // bit-change charge sequence and clear
        send(24'h000000);
        send(24'hFFFFFF);
        send(24'h000000);
        tick(3 * OSR);
        charge_clr = 1'b1;
        tick(1);
        charge_clr = 1'b0;
        tick(2 * OSR);

        // randomized codes, gaps and enable drops
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                enable = 1'b0;
                tick($urandom_range(1, 3 * OSR));
                enable = 1'b1;
            end
            case ($urandom_range(0, 5))
                0:       code = 24'h800000;
                1:       code = 24'h7FFFFF;
                default: code = 24'($urandom);
            endcase
            send(code);
            tick($urandom_range(0, 2 * OSR));
        end
        tick(4 * OSR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
